reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter ZERO_RO, default 0; when 1, writes addressed to register 0 are accepted and then discarded (no RegWrite pulse).
REQ-002 Parameter CNT_W, default 8; width of the stall counter.
REQ-003 Timing: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 alu_valid  input  1  ALU write-back request.
REQ-007 alu_addr  input  4  ALU destination register.
REQ-008 alu_data  input  16  ALU write data.
REQ-009 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-010 mem_valid  input  1  load write-back request.
REQ-011 mem_addr  input  4  load destination register.
REQ-012 mem_data  input  16  load write data.
REQ-013 mem_ready  output  1  load request accepted this cycle (combinational).
REQ-014 RegWrite  output  1  register-file write enable (registered).
REQ-015 AddrC  output  4  register-file write address (registered).
REQ-016 BusC  output  16  register-file write data (registered).
REQ-017 stall_cnt  output  CNT_W  saturating count of cycles in which any valid requester was not accepted.

Function
REQ-018 The block shall share the single register-file write port between ALU and MEM requesters; a transfer occurs when valid and ready are both 1 in the same cycle.
REQ-019 Exactly one requester valid: its ready shall be 1 that cycle (no back-pressure).
REQ-020 Neither valid: both readies 0; RegWrite 0 in the following cycle.
REQ-021 Both valid, different addresses: grant the requester indicated by a 1-bit round-robin pointer rr (0=ALU, 1=MEM); the other sees ready 0.
REQ-022 Both valid, same address: MEM shall be granted regardless of rr (ALU result is younger and must land last).
REQ-023 After any accepted transfer, rr shall point to the requester that was not granted.
REQ-024 Latency: a transfer accepted in cycle t shall appear as RegWrite=1, AddrC, BusC during cycle t+1, committing at the rising edge ending cycle t+1.
REQ-025 RegWrite shall be 1 for exactly one cycle per accepted transfer; AddrC/BusC hold their last values when RegWrite is 0.
REQ-026 ZERO_RO=1 and accepted address 0: ready still 1, rr still updates, RegWrite 0 in t+1.
REQ-027 stall_cnt shall increment by 1 in any cycle where a valid requester has ready 0, and saturate at all-ones with no wrap.
REQ-028 A non-granted requester holding valid shall be granted no later than the next cycle (starvation bound of one cycle).
REQ-029 Requester inputs may change only after acceptance; the block need not check this.

Reset
REQ-030 While rst=1: RegWrite=0, AddrC=0, BusC=0, stall_cnt=0, rr=0 (ALU first), alu_ready=0, mem_ready=0.
REQ-031 Assertion of rst during cycle t+1 of a pending write shall deassert RegWrite immediately; that write is lost.
REQ-032 First rising edge after rst deasserts shall perform normal arbitration.

Verification
REQ-033 Reset, then alu_valid=1 addr=3 data=0x00A5 for one cycle -> alu_ready=1 same cycle; next cycle RegWrite=1, AddrC=3, BusC=0x00A5; following cycle RegWrite=0.
REQ-034 Both valid for 4 cycles, alu addr=1, mem addr=2, rr=0 -> grants ALU,MEM,ALU,MEM; stall_cnt=4.
REQ-035 Both valid same cycle, addr=7, alu_data=0x1111, mem_data=0x2222, rr=0 -> MEM granted first, ALU next; regfile R7=0x1111 after both writes.
REQ-036 ZERO_RO=1, mem_valid addr=0 data=0xFFFF -> mem_ready=1, no RegWrite pulse; ZERO_RO=0 same stimulus -> RegWrite=1, AddrC=0.
REQ-037 CNT_W=2, both valid 6 cycles -> stall_cnt reaches 3 and holds.
REQ-038 Assert rst in the cycle RegWrite=1 (addr=5) -> RegWrite drops before the edge; R5 unchanged; all outputs zero.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port between ALU and load write-back; one-cycle registered write.
// Readies are combinational; the loser of a conflict waits at most one cycle via a round-robin pointer.
module reg_wb_arbiter #(
    parameter bit ZERO_RO = 1'b0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [3:0]       alu_addr,
    input  logic [15:0]      alu_data,
    output logic             alu_ready,
    input  logic             mem_valid,
    input  logic [3:0]       mem_addr,
    input  logic [15:0]      mem_data,
    output logic             mem_ready,
    output logic             RegWrite,
    output logic [3:0]       AddrC,
    output logic [15:0]      BusC,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        rr;
    logic        grantAlu;
    logic        grantMem;
    logic        accept;
    logic        discard;
    logic        stalled;
    logic [3:0]  selAddr;
    logic [15:0] selData;

    // A same-address collision always goes to MEM so the younger ALU result lands last.
    always_comb begin
        grantMem = mem_valid & (~alu_valid | (alu_addr == mem_addr) | rr);
        grantAlu = alu_valid & ~grantMem;
        accept   = grantAlu | grantMem;
        selAddr  = grantMem ? mem_addr : alu_addr;
        selData  = grantMem ? mem_data : alu_data;
        discard  = ZERO_RO && (selAddr == 4'd0);
        stalled  = (alu_valid & ~grantAlu) | (mem_valid & ~grantMem);
    end

    assign alu_ready = grantAlu & ~rst;
    assign mem_ready = grantMem & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            AddrC     <= 4'd0;
            BusC      <= 16'd0;
            rr        <= 1'b0;
            stall_cnt <= '0;
        end else begin
            RegWrite <= accept & ~discard;
            if (accept & ~discard) begin
                AddrC <= selAddr;
                BusC  <= selData;
            end
            if (accept) begin
                rr <= grantAlu;
            end
            if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: three parameterisations driven in parallel against a rule-level model.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;

    logic [2:0]  aRdy;
    logic [2:0]  mRdy;
    logic [2:0]  rw;
    logic [3:0]  ac [3];
    logic [15:0] bc [3];
    logic [7:0]  sc0;
    logic [7:0]  sc1;
    logic [1:0]  sc2;

    int nCmp = 0;
    int nErr = 0;

    reg_wb_arbiter dut0 (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(aRdy[0]),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mRdy[0]),
        .RegWrite(rw[0]), .AddrC(ac[0]), .BusC(bc[0]), .stall_cnt(sc0)
    );

    reg_wb_arbiter #(.ZERO_RO(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(aRdy[1]),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mRdy[1]),
        .RegWrite(rw[1]), .AddrC(ac[1]), .BusC(bc[1]), .stall_cnt(sc1)
    );

    reg_wb_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(aRdy[2]),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mRdy[2]),
        .RegWrite(rw[2]), .AddrC(ac[2]), .BusC(bc[2]), .stall_cnt(sc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance configuration seen by the model.
    bit zro  [3] = '{1'b0, 1'b1, 1'b0};
    int cmax [3] = '{255, 255, 3};

    // Model state: who is favoured next, total stalled cycles, and the pending write per instance.
    bit          mRr;
    int          mStall;
    bit          mRw   [3];
    logic [3:0]  mAddr [3];
    logic [15:0] mData [3];
    bit          lastGa;
    bit          lastGm;
    logic [15:0] rf0 [16];

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    function automatic void predict(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (alu_valid && !mem_valid)       ga = 1'b1;
        else if (mem_valid && !alu_valid)  gm = 1'b1;
        else if (alu_valid && mem_valid) begin
            if (alu_addr == mem_addr) gm = 1'b1;
            else if (mRr)             gm = 1'b1;
            else                      ga = 1'b1;
        end
    endfunction

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) rf0[i] = 16'd0;
    end

    always @(posedge clk) begin
        bit ga, gm, wr;
        if (rw[0]) rf0[ac[0]] = bc[0];
        if (rst) begin
            mRr = 1'b0;
            mStall = 0;
            lastGa = 1'b0;
            lastGm = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mRw[i] = 1'b0; mAddr[i] = 4'd0; mData[i] = 16'd0;
            end
        end else begin
            predict(ga, gm);
            if ((alu_valid && !ga) || (mem_valid && !gm)) mStall++;
            for (int i = 0; i < 3; i++) begin
                wr = (ga || gm) && !(zro[i] && ((gm ? mem_addr : alu_addr) == 4'd0));
                mRw[i] = wr;
                if (wr) begin
                    mAddr[i] = gm ? mem_addr : alu_addr;
                    mData[i] = gm ? mem_data : alu_data;
                end
            end
            if (ga) mRr = 1'b1;
            if (gm) mRr = 1'b0;
            lastGa = ga;
            lastGm = gm;
        end
    end

    always @(negedge clk) begin
        bit ga, gm;
        int sc [3];
        predict(ga, gm);
        sc[0] = int'(sc0); sc[1] = int'(sc1); sc[2] = int'(sc2);
        for (int i = 0; i < 3; i++) begin
            chk("alu_ready", i, int'(aRdy[i]), rst ? 0 : int'(ga));
            chk("mem_ready", i, int'(mRdy[i]), rst ? 0 : int'(gm));
            chk("RegWrite",  i, int'(rw[i]),   rst ? 0 : int'(mRw[i]));
            chk("AddrC",     i, int'(ac[i]),   rst ? 0 : int'(mAddr[i]));
            chk("BusC",      i, int'(bc[i]),   rst ? 0 : int'(mData[i]));
            chk("stall_cnt", i, sc[i],         rst ? 0 : minInt(mStall, cmax[i]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h0002;
        #2;
        chk("rst_alu_ready", 0, int'(aRdy[0]), 0);
        chk("rst_mem_ready", 0, int'(mRdy[0]), 0);
        chk("rst_RegWrite",  0, int'(rw[0]), 0);
        chk("rst_stall",     0, int'(sc0), 0);
        cyc(); cyc();
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;

        // Single ALU write, one-cycle latency.
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h00A5;
        #1 chk("single_alu_ready", 0, int'(aRdy[0]), 1);
        cyc();
        alu_valid = 1'b0;
        #1;
        chk("single_rw",   0, int'(rw[0]), 1);
        chk("single_addr", 0, int'(ac[0]), 3);
        chk("single_data", 0, int'(bc[0]), 16'h00A5);
        cyc();
        chk("single_rw_drop", 0, int'(rw[0]), 0);

        // Alternating grants with saturating stall counter on the CNT_W=2 instance.
        doReset();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'h0101;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h0202;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_alu_grant", k, int'(aRdy[0]), (k % 2 == 0) ? 1 : 0);
            chk("rr_mem_grant", k, int'(mRdy[0]), (k % 2 == 1) ? 1 : 0);
            cyc();
            if (k == 3) begin
                chk("stall_after4",   0, int'(sc0), 4);
                chk("stall_sat_at4",  2, int'(sc2), 3);
            end
        end
        chk("stall_after6",  0, int'(sc0), 6);
        chk("stall_sat_at6", 2, int'(sc2), 3);
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Same-address collision: MEM first, ALU last.
        doReset();
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'h2222;
        #1;
        chk("same_mem_first", 0, int'(mRdy[0]), 1);
        chk("same_alu_wait",  0, int'(aRdy[0]), 0);
        cyc();
        mem_valid = 1'b0;
        #1;
        chk("same_alu_next", 0, int'(aRdy[0]), 1);
        chk("same_w1_addr",  0, int'(ac[0]), 7);
        chk("same_w1_data",  0, int'(bc[0]), 16'h2222);
        cyc();
        alu_valid = 1'b0;
        #1 chk("same_w2_data", 0, int'(bc[0]), 16'h1111);
        cyc();
        chk("same_r7", 0, int'(rf0[7]), 16'h1111);

        // Writes to register 0 with and without the read-only option.
        mem_valid = 1'b1; mem_addr = 4'd0; mem_data = 16'hFFFF;
        #1;
        chk("zero_ro_ready", 1, int'(mRdy[1]), 1);
        chk("zero_rw_ready", 0, int'(mRdy[0]), 1);
        cyc();
        mem_valid = 1'b0;
        #1;
        chk("zero_ro_nowrite", 1, int'(rw[1]), 0);
        chk("zero_ro_hold",    1, int'(ac[1]), 7);
        chk("zero_rw_write",   0, int'(rw[0]), 1);
        chk("zero_rw_addr",    0, int'(ac[0]), 0);
        chk("zero_rw_data",    0, int'(bc[0]), 16'hFFFF);
        cyc();

        // Reset during a pending write loses that write.
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'h1234;
        cyc();
        alu_data = 16'hBEEF;
        cyc();
        alu_valid = 1'b0;
        #1;
        chk("abort_rw_before", 0, int'(rw[0]), 1);
        chk("abort_data",      0, int'(bc[0]), 16'hBEEF);
        #1 rst = 1'b1;
        #1;
        chk("abort_rw",    0, int'(rw[0]), 0);
        chk("abort_addr",  0, int'(ac[0]), 0);
        chk("abort_busc",  0, int'(bc[0]), 0);
        chk("abort_stall", 0, int'(sc0), 0);
        cyc();
        rst = 1'b0;
        chk("abort_r5", 0, int'(rf0[5]), 16'h1234);

        // Randomised traffic; held requests only change after acceptance.
        for (int n = 0; n < 2000; n++) begin
            rst = (n % 400 == 200);
            if (!alu_valid || lastGa) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = 4'($urandom_range(0, 3));
                alu_data  = 16'($urandom);
            end
            if (!mem_valid || lastGm) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_addr  = 4'($urandom_range(0, 3));
                mem_data  = 16'($urandom);
            end
            cyc();
        end
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
